reg_bank_rr_arb: RTL and testbench

- Shares one write port of a small register bank between REQ_NUM requesters using round-robin arbitration with a valid/ready handshake.
- Writes land one cycle after the handshake and are reported by a done pulse tagged with the requester ID.
- A combinational read port serves CSR/status readers.
- Sits between multiple config masters (bus bridge, debug, DMA descriptors) and a shared configuration register set.

---
 rtl/reg_bank_pkg.sv | 24 ++
 rtl/reg_bank_rr_arb_if.sv | 36 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/reg_bank_rr_arb.sv | 112 +++++++++++
 tb/tb_reg_bank_rr_arb.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the round-robin arbitrated register bank.
// - Parameter ceilings for requester and register counts.
// - wr_stage_t: payload held in the one-cycle write stage, sized for the ceilings.
// - idx_slice(): bit offset of slice idx in a packed per-requester bus.
package reg_bank_pkg;

  localparam int unsigned MaxReqNum    = 8;
  localparam int unsigned MaxRegNum    = 256;
  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxIdWidth   = $clog2(MaxReqNum);
  localparam int unsigned MaxAddrWidth = $clog2(MaxRegNum);

  // Fields are ceiling-sized; instances zero-extend into them.
  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxDataWidth-1:0] data;
    logic [MaxIdWidth-1:0]   id;
  } wr_stage_t;

  function automatic int unsigned idx_slice(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_bank_rr_arb_if.sv
// Bus between the config requesters and the shared register bank.
// - req_valid_i / req_ready_o : per-requester write handshake
// - req_addr_i / req_dat_i    : packed per-requester payload, requester i uses slice i
// - wr_done_o / wr_id_o / wr_err_o : completion report, one cycle after the handshake
// - rd_addr_i / rd_dat_o      : combinational read port
// Signal suffixes are relative to the bank (slave side).
interface reg_bank_rr_arb_if #(
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned REG_NUM    = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned ADDR_WIDTH = $clog2(REG_NUM);
  localparam int unsigned ID_WIDTH   = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]            req_valid_i;
  logic [REQ_NUM-1:0]            req_ready_o;
  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr_i;
  logic [REQ_NUM*DATA_WIDTH-1:0] req_dat_i;
  logic                          wr_done_o;
  logic [ID_WIDTH-1:0]           wr_id_o;
  logic                          wr_err_o;
  logic [ADDR_WIDTH-1:0]         rd_addr_i;
  logic [DATA_WIDTH-1:0]         rd_dat_o;

  modport master (
    output req_valid_i, req_addr_i, req_dat_i, rd_addr_i,
    input  req_ready_o, wr_done_o, wr_id_o, wr_err_o, rd_dat_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_dat_i, rd_addr_i,
    output req_ready_o, wr_done_o, wr_id_o, wr_err_o, rd_dat_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// - clk_i, rst_i : clock, asynchronous active-high reset (pointer -> 0)
// - req_i        : request vector
// - advance_i    : the current grant was accepted; move pointer past the winner
// - gnt_o        : one-hot (or zero) grant, combinational
// - gnt_idx_o    : index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int unsigned REQ_NUM = 4,
  localparam int unsigned ID_WIDTH = $clog2(REQ_NUM)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [REQ_NUM-1:0]  req_i,
  input  logic                advance_i,
  output logic [REQ_NUM-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] gnt_idx_o
);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                found;
  int unsigned         idx;

  // Scan from the pointer, wrapping modulo REQ_NUM (need not be a power of two).
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = gnt_idx_o + 1'b1;
    if (32'(gnt_idx_o) == REQ_NUM - 1) ptr_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_bank_rr_arb.sv
// Register bank with one write port shared by REQ_NUM requesters (round robin).
// - clk_i : clock, rising edge
// - rst_i : asynchronous active-high reset; clears bank, pointer, write stage
// - clr_i : synchronous clear of the whole bank; blocks grants, discards staged write
// - bus   : slave modport of reg_bank_rr_arb_if (handshake, completion, read port)
// A granted write is captured into the stage on the handshake edge (wr_done_o is high
// the following cycle) and lands in the bank on the next edge. Reads never bypass.
module reg_bank_rr_arb
  import reg_bank_pkg::*;
#(
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned REG_NUM    = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  reg_bank_rr_arb_if.slave      bus
);

  localparam int unsigned ADDR_WIDTH = $clog2(REG_NUM);
  localparam int unsigned ID_WIDTH   = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]    req_masked;
  logic [REQ_NUM-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  xfer;
  wr_stage_t             stage_q, stage_d;
  logic                  stage_valid_q;
  logic                  stage_in_range;
  logic [DATA_WIDTH-1:0] bank_q [REG_NUM];
  logic [DATA_WIDTH-1:0] rd_dat;

  // Nobody is granted while clearing or in reset.
  assign req_masked = bus.req_valid_i & {REQ_NUM{~(clr_i | rst_i)}};

  rr_arbiter #(
    .REQ_NUM(REQ_NUM)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_masked),
    .advance_i(xfer),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  assign xfer            = |gnt;
  assign bus.req_ready_o = gnt;

  always_comb begin
    stage_d      = '0;
    stage_d.addr = MaxAddrWidth'(bus.req_addr_i[idx_slice(32'(gnt_idx), ADDR_WIDTH) +: ADDR_WIDTH]);
    stage_d.data = MaxDataWidth'(bus.req_dat_i[idx_slice(32'(gnt_idx), DATA_WIDTH) +: DATA_WIDTH]);
    stage_d.id   = MaxIdWidth'(gnt_idx);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
    end else begin
      stage_valid_q <= xfer;
      if (xfer) stage_q <= stage_d;
    end
  end

  assign stage_in_range = 32'(stage_q.addr) < REG_NUM;

  // Clear wins over a staged write, which is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < REG_NUM; r++) bank_q[r] <= '0;
    end else if (clr_i) begin
      for (int unsigned r = 0; r < REG_NUM; r++) bank_q[r] <= '0;
    end else if (stage_valid_q && stage_in_range) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        if (32'(stage_q.addr) == r) bank_q[r] <= stage_q.data[DATA_WIDTH-1:0];
      end
    end
  end

  // Done still pulses for a write dropped by clr_i, but never flagged as an error.
  assign bus.wr_done_o = stage_valid_q;
  assign bus.wr_id_o   = stage_q.id[ID_WIDTH-1:0];
  assign bus.wr_err_o  = stage_valid_q & ~stage_in_range & ~clr_i;

  always_comb begin
    rd_dat = '0;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      if (32'(bus.rd_addr_i) == r) rd_dat = bank_q[r];
    end
  end

  assign bus.rd_dat_o = rd_dat;

  // Ceiling-sized stage fields have upper bits that are never read.
  logic unused_stage_bits;
  assign unused_stage_bits = ^stage_q;

  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.req_ready_o))
    else $error("req_ready_o has more than one bit set");

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_stable
    assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.req_valid_i[gi] && !bus.req_ready_o[gi]) |=>
        ($stable(bus.req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]) &&
         $stable(bus.req_dat_i[gi*DATA_WIDTH +: DATA_WIDTH])))
      else $error("requester %0d changed payload while waiting", gi);
  end

endmodule

// File: tb/tb_reg_bank_rr_arb.sv
module tb_reg_bank_rr_arb;

  localparam int unsigned REQ_NUM    = 4;
  localparam int unsigned REG_NUM    = 6;
  localparam int unsigned DATA_WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  reg_bank_rr_arb_if #(
    .REQ_NUM   (REQ_NUM),
    .REG_NUM   (REG_NUM),
    .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  reg_bank_rr_arb #(
    .REQ_NUM   (REQ_NUM),
    .REG_NUM   (REG_NUM),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  valid;
    logic        clr;
    logic [11:0] addr;
    logic [2:0]  rd_addr;
    logic [3:0]  exp_ready;
    logic        exp_done;
    logic [1:0]  exp_id;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[18];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [11:0] ab, ae, ac, aa;
  logic [127:0] dbus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  function automatic logic [11:0] pack_addr(input logic [2:0] a3, input logic [2:0] a2,
                                            input logic [2:0] a1, input logic [2:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  // Data written by requester i to address a: 0xC0DE_0000 + a*0x100 + i.
  function automatic logic [127:0] dat_bus(input logic [11:0] a);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'hC0DE_0000 + 32'(a[i*3 +: 3]) * 32'h100 + 32'(i);
    return d;
  endfunction

  task automatic drive(input logic [3:0] v, input logic c, input logic [11:0] a,
                       input logic [2:0] r);
    bus.req_valid_i = v;
    clr             = c;
    bus.req_addr_i  = a;
    bus.req_dat_i   = dat_bus(a);
    bus.rd_addr_i   = r;
  endtask

  initial begin
    ab = pack_addr(3'd3, 3'd2, 3'd1, 3'd0);
    ae = pack_addr(3'd3, 3'd2, 3'd7, 3'd0);
    ac = pack_addr(3'd3, 3'd4, 3'd7, 3'd0);
    //          valid  clr   addr rd     ready  done  id     err   rd_dat
    vecs[0]  = '{4'hF, 1'b0, ab, 3'd0, 4'h1, 1'b0, 2'd0, 1'b0, 32'h0};
    vecs[1]  = '{4'hF, 1'b0, ab, 3'd0, 4'h2, 1'b1, 2'd0, 1'b0, 32'h0};
    vecs[2]  = '{4'hF, 1'b0, ab, 3'd0, 4'h4, 1'b1, 2'd1, 1'b0, 32'hC0DE_0000};
    vecs[3]  = '{4'hF, 1'b0, ab, 3'd1, 4'h8, 1'b1, 2'd2, 1'b0, 32'hC0DE_0101};
    vecs[4]  = '{4'hF, 1'b0, ab, 3'd2, 4'h1, 1'b1, 2'd3, 1'b0, 32'hC0DE_0202};
    vecs[5]  = '{4'h0, 1'b0, ab, 3'd3, 4'h0, 1'b1, 2'd0, 1'b0, 32'hC0DE_0303};
    vecs[6]  = '{4'h9, 1'b0, ab, 3'd5, 4'h8, 1'b0, 2'd0, 1'b0, 32'h0};
    vecs[7]  = '{4'h9, 1'b0, ab, 3'd4, 4'h1, 1'b1, 2'd3, 1'b0, 32'h0};
    vecs[8]  = '{4'h9, 1'b0, ab, 3'd0, 4'h8, 1'b1, 2'd0, 1'b0, 32'hC0DE_0000};
    vecs[9]  = '{4'hA, 1'b0, ae, 3'd3, 4'h2, 1'b1, 2'd3, 1'b0, 32'hC0DE_0303};
    vecs[10] = '{4'h8, 1'b0, ae, 3'd1, 4'h8, 1'b1, 2'd1, 1'b1, 32'hC0DE_0101};
    vecs[11] = '{4'h0, 1'b0, ae, 3'd7, 4'h0, 1'b1, 2'd3, 1'b0, 32'h0};
    vecs[12] = '{4'h0, 1'b0, ae, 3'd2, 4'h0, 1'b0, 2'd0, 1'b0, 32'hC0DE_0202};
    vecs[13] = '{4'h4, 1'b0, ac, 3'd4, 4'h4, 1'b0, 2'd0, 1'b0, 32'h0};
    vecs[14] = '{4'h1, 1'b1, ac, 3'd3, 4'h0, 1'b1, 2'd2, 1'b0, 32'hC0DE_0303};
    vecs[15] = '{4'h1, 1'b0, ac, 3'd3, 4'h1, 1'b0, 2'd0, 1'b0, 32'h0};
    vecs[16] = '{4'h0, 1'b0, ac, 3'd4, 4'h0, 1'b1, 2'd0, 1'b0, 32'h0};
    vecs[17] = '{4'h0, 1'b0, ac, 3'd0, 4'h0, 1'b0, 2'd0, 1'b0, 32'hC0DE_0000};

    // Reset state, with every requester asking.
    drive(4'hF, 1'b0, ab, 3'd0);
    #1 rst = 1'b1;
    #2;
    check("reset ready", 32'(bus.req_ready_o), 32'h0);
    check("reset done", 32'(bus.wr_done_o), 32'h0);
    check("reset id", 32'(bus.wr_id_o), 32'h0);
    check("reset err", 32'(bus.wr_err_o), 32'h0);
    check("reset rd", bus.rd_dat_o, 32'h0);
    bus.req_valid_i = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      drive(vecs[k].valid, vecs[k].clr, vecs[k].addr, vecs[k].rd_addr);
      #1;
      check($sformatf("v%0d ready", k), 32'(bus.req_ready_o), 32'(vecs[k].exp_ready));
      check($sformatf("v%0d done", k), 32'(bus.wr_done_o), 32'(vecs[k].exp_done));
      if (vecs[k].exp_done) check($sformatf("v%0d id", k), 32'(bus.wr_id_o), 32'(vecs[k].exp_id));
      check($sformatf("v%0d err", k), 32'(bus.wr_err_o), 32'(vecs[k].exp_err));
      check($sformatf("v%0d rd", k), bus.rd_dat_o, vecs[k].exp_rd);
    end

    // Lone requester 2 writes 0xDEADBEEF to address 5 (pointer is 1 here).
    @(negedge clk);
    aa = pack_addr(3'd3, 3'd5, 3'd7, 3'd0);
    drive(4'h4, 1'b0, aa, 3'd5);
    dbus = dat_bus(aa);
    dbus[64 +: 32] = 32'hDEAD_BEEF;
    bus.req_dat_i = dbus;
    #1;
    check("solo ready", 32'(bus.req_ready_o), 32'h4);
    @(negedge clk);
    bus.req_valid_i = 4'h0;
    #1;
    check("solo done", 32'(bus.wr_done_o), 32'h1);
    check("solo id", 32'(bus.wr_id_o), 32'h2);
    check("solo err", 32'(bus.wr_err_o), 32'h0);
    check("solo rd old", bus.rd_dat_o, 32'h0);
    @(negedge clk);
    #1;
    check("solo done end", 32'(bus.wr_done_o), 32'h0);
    check("solo rd new", bus.rd_dat_o, 32'hDEAD_BEEF);
    bus.rd_addr_i = 3'd0;
    #1 check("solo rd other", bus.rd_dat_o, 32'hC0DE_0000);

    // Asynchronous reset with a write in the stage (pointer is 3 here).
    @(negedge clk);
    drive(4'hF, 1'b0, ab, 3'd0);
    #1 check("arst pre ready", 32'(bus.req_ready_o), 32'h8);
    @(posedge clk);
    #2;
    check("arst inflight done", 32'(bus.wr_done_o), 32'h1);
    check("arst inflight id", 32'(bus.wr_id_o), 32'h3);
    rst = 1'b1;
    #1;
    check("arst ready", 32'(bus.req_ready_o), 32'h0);
    check("arst done", 32'(bus.wr_done_o), 32'h0);
    check("arst id", 32'(bus.wr_id_o), 32'h0);
    check("arst rd0", bus.rd_dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post-reset ready", 32'(bus.req_ready_o), 32'h1);
    @(negedge clk);
    bus.req_valid_i = 4'h0;
    #1;
    check("post-reset done", 32'(bus.wr_done_o), 32'h1);
    check("post-reset id", 32'(bus.wr_id_o), 32'h0);
    @(negedge clk);
    #1;
    check("post-reset rd0", bus.rd_dat_o, 32'hC0DE_0000);
    bus.rd_addr_i = 3'd3;
    #1 check("lost write rd3", bus.rd_dat_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
